// File: rtl/regfile_wr_sched.sv
// Round-robin scheduler for the single regfile write port shared by the
// execute and memory writeback producers, plus a per-register busy scoreboard.
module regfile_wr_sched #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_reg,
    input  logic [ADDR_W-1:0] chk_reg1,
    input  logic [ADDR_W-1:0] chk_reg2,
    output logic              busy1,
    output logic              busy2
);

    localparam int NREGS = 1 << ADDR_W;

    logic              ptr;
    logic              grant;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic              grant_wr;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  set_vec;
    logic [NREGS-1:0]  clr_vec;
    logic [NREGS-1:0]  busy_nxt;

    always_comb begin
        wr0_ready = wr0_valid && (!wr1_valid || !ptr);
        wr1_ready = wr1_valid && (!wr0_valid || ptr);
    end

    always_comb begin
        grant      = wr0_ready || wr1_ready;
        grant_addr = wr1_ready ? wr1_addr : wr0_addr;
        grant_data = wr1_ready ? wr1_data : wr0_data;
        grant_wr   = grant && (grant_addr != ADDR_W'(ZERO_REG));
    end

    // On contention the winner is whoever ptr names, so toggling leaves it on the loser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (wr0_valid && wr1_valid) begin
            ptr <= ~ptr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= grant_wr;
            if (grant_wr) begin
                WriteRegister <= grant_addr;
                WriteData     <= grant_data;
            end
        end
    end

    // Set after clear so a claim on the capture edge keeps the bit for the new producer.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (claim_valid) set_vec[claim_reg] = 1'b1;
        if (RegWrite)    clr_vec[WriteRegister] = 1'b1;
        busy_nxt = (busy & ~clr_vec) | set_vec;
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        busy1 = busy[chk_reg1];
        busy2 = busy[chk_reg2];
    end

endmodule
